// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32 pipeline.
// Fetch-side bundles live here so decode can import them too.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } if_id_t;

  function automatic logic [XLEN-1:0] align_word(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

  function automatic if_id_t to_if_id(input fetch_entry_t e);
    if_id_t r;
    r.valid    = 1'b1;
    r.pc       = e.pc;
    r.pc_plus4 = e.pc + 32'd4;
    r.instr    = e.instr;
    return r;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer between instruction memory and the IF/ID register.
// Power-of-two depth so the pointers wrap naturally.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, one-deep imem request, prefetch FIFO
// and the IF/ID register feeding decode.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            stall_id,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] tag_pc;
  logic            outstanding;
  logic            tag;
  logic            epoch;
  logic [CW-1:0]   count;
  fetch_entry_t    head;
  fetch_entry_t    resp_entry;
  if_id_t          if_id;

  logic hs;
  logic resp;
  logic accept;
  logic can_load;
  logic bypass;
  logic push;
  logic pop;

  // Only one request in flight, so occupancy+outstanding is just count.
  assign imem_req_valid = rst & ~outstanding & ~redirect_valid
                        & (count < CW'(FIFO_DEPTH));
  assign imem_addr = align_word(pc);

  assign hs       = imem_req_valid & imem_req_ready;
  assign resp     = imem_resp_valid & outstanding;
  assign accept   = resp & (tag == epoch) & ~redirect_valid;
  assign can_load = ~stall_id & ~redirect_valid;
  assign bypass   = accept & can_load & (count == '0);
  assign push     = accept & ~bypass;
  assign pop      = can_load & (count != '0);

  assign resp_entry = '{pc: tag_pc, instr: imem_resp_data};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (resp_entry),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= align_word(RESET_PC);
      outstanding <= 1'b0;
      tag         <= 1'b0;
      epoch       <= 1'b0;
      tag_pc      <= '0;
    end else begin
      if (resp) outstanding <= 1'b0;
      if (hs) begin
        pc          <= pc + 32'd4;
        outstanding <= 1'b1;
        tag         <= epoch;
        tag_pc      <= imem_addr;
      end
      // Retag any in-flight fetch as stale, even across back-to-back redirects.
      if (redirect_valid) begin
        epoch <= ~epoch;
        tag   <= epoch;
        pc    <= align_word(redirect_pc);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_id <= '{valid: 1'b0, pc: '0, pc_plus4: '0, instr: NOP_INSTR};
    end else if (redirect_valid) begin
      if_id.valid <= 1'b0;
      if_id.instr <= NOP_INSTR;
    end else if (!stall_id) begin
      unique case (1'b1)
        bypass: if_id <= to_if_id(resp_entry);
        pop:    if_id <= to_if_id(head);
        default: begin
          if_id.valid <= 1'b0;
          if_id.instr <= NOP_INSTR;
        end
      endcase
    end
  end

  assign if_id_valid    = if_id.valid;
  assign if_id_instr    = if_id.instr;
  assign if_id_pc       = if_id.pc;
  assign if_id_pc_plus4 = if_id.pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table, directed corner sequences,
// and random traffic against a PC-stream reference model.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam logic [31:0] K = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        stall_id = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .stall_id        (stall_id),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .if_id_valid     (if_id_valid),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus4  (if_id_pc_plus4)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 1;
  int deliveries = 0;
  bit rand_lat = 1'b0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  // Reference: decode must see consecutive PCs from the last reset/redirect.
  logic [31:0] exp_pc = '0;
  bit          p_rst = 1'b0;
  bit          p_st = 1'b0;
  bit          p_rv = 1'b0;
  logic [31:0] p_rpc = '0;
  bit          p_wait = 1'b0;
  logic [31:0] p_addr = '0;
  logic        s_iv = 1'b0;
  logic [31:0] s_instr = '0;
  logic [31:0] s_pc = '0;
  logic [31:0] s_p4 = '0;
  bit          last_hs = 1'b0;
  logic [31:0] last_hs_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic check_if();
    if (!p_rst) begin
      chk("rst_if_valid", 32'(if_id_valid), 0);
      chk("rst_if_instr", if_id_instr, NOP);
      chk("rst_if_pc", if_id_pc, 0);
      chk("rst_if_p4", if_id_pc_plus4, 0);
    end else if (p_rv) begin
      chk("redir_if_valid", 32'(if_id_valid), 0);
      chk("redir_if_instr", if_id_instr, NOP);
      exp_pc = {p_rpc[31:2], 2'b00};
    end else if (p_st) begin
      chk("stall_hold_valid", 32'(if_id_valid), 32'(s_iv));
      chk("stall_hold_instr", if_id_instr, s_instr);
      chk("stall_hold_pc", if_id_pc, s_pc);
      chk("stall_hold_p4", if_id_pc_plus4, s_p4);
    end else if (if_id_valid) begin
      chk("stream_pc", if_id_pc, exp_pc);
      chk("stream_instr", if_id_instr, exp_pc ^ K);
      chk("stream_p4", if_id_pc_plus4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      deliveries++;
    end else begin
      chk("bubble_instr", if_id_instr, NOP);
    end
    s_iv = if_id_valid;
    s_instr = if_id_instr;
    s_pc = if_id_pc;
    s_p4 = if_id_pc_plus4;
  endtask

  task automatic step(input bit r, input bit st, input bit rdy,
                      input bit rv, input logic [31:0] rpc);
    int d;
    @(negedge clk);
    cyc++;
    check_if();
    rst = r;
    stall_id = st;
    imem_req_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data = mq[0].addr ^ K;
      void'(mq.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data = $urandom;
    end
    #1;
    if (!r) begin
      chk("rst_req_valid", 32'(imem_req_valid), 0);
      chk("rst_now_if_valid", 32'(if_id_valid), 0);
      chk("rst_now_instr", if_id_instr, NOP);
      exp_pc = 32'h0;
    end else begin
      if (rv)
        chk("req_drop_redirect", 32'(imem_req_valid), 0);
      else if (p_wait) begin
        chk("req_hold_valid", 32'(imem_req_valid), 1);
        chk("req_hold_addr", imem_addr, p_addr);
      end
      if (imem_req_valid)
        chk("addr_align", 32'(imem_addr[1:0]), 0);
    end
    last_hs = r && imem_req_valid && rdy;
    last_hs_addr = imem_addr;
    if (last_hs) begin
      d = rand_lat ? int'($urandom_range(1, 4)) : lat;
      mq.push_back('{addr: imem_addr, due: cyc + d});
    end
    p_wait = r && imem_req_valid && !rdy;
    p_addr = imem_addr;
    p_rst = r;
    p_st = st;
    p_rv = rv;
    p_rpc = rpc;
  endtask

  task automatic run(input bit st, input bit rdy);
    step(1'b1, st, rdy, 1'b0, 32'h0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  typedef struct {
    bit          st;
    bit          rdy;
    bit          exp_rv;
    logic [31:0] exp_addr;
    bit          exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int last_del;
    int idle;
    logic [31:0] rpc;

    // Cycle 0 is the first cycle after reset release; 1-cycle memory.
    tbl[0]  = '{0, 1, 1, 32'h00, 0, 32'h00};
    tbl[1]  = '{0, 1, 0, 32'h00, 0, 32'h00};
    tbl[2]  = '{0, 1, 1, 32'h04, 1, 32'h00};
    tbl[3]  = '{0, 1, 0, 32'h00, 0, 32'h00};
    tbl[4]  = '{0, 1, 1, 32'h08, 1, 32'h04};
    tbl[5]  = '{0, 1, 0, 32'h00, 0, 32'h00};
    tbl[6]  = '{0, 1, 1, 32'h0C, 1, 32'h08};
    tbl[7]  = '{0, 1, 0, 32'h00, 0, 32'h00};
    tbl[8]  = '{0, 0, 1, 32'h10, 1, 32'h0C};
    tbl[9]  = '{0, 1, 1, 32'h10, 0, 32'h00};
    tbl[10] = '{1, 1, 0, 32'h00, 0, 32'h00};
    tbl[11] = '{0, 1, 1, 32'h14, 0, 32'h00};
    tbl[12] = '{0, 1, 0, 32'h00, 1, 32'h10};

    lat = 1;
    do_reset(2);
    for (int i = 0; i < 13; i++) begin
      run(tbl[i].st, tbl[i].rdy);
      chk($sformatf("tbl%0d_req_valid", i), 32'(imem_req_valid),
          32'(tbl[i].exp_rv));
      if (tbl[i].exp_rv)
        chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_if_valid", i), 32'(if_id_valid),
          32'(tbl[i].exp_iv));
      if (tbl[i].exp_iv)
        chk($sformatf("tbl%0d_if_pc", i), if_id_pc, tbl[i].exp_pc);
    end

    // Memory not ready: request held at RESET_PC.
    do_reset(2);
    for (int i = 0; i < 5; i++) begin
      run(1'b0, 1'b0);
      chk("wait_req_valid", 32'(imem_req_valid), 1);
      chk("wait_addr", imem_addr, 32'h0);
      chk("wait_if_valid", 32'(if_id_valid), 0);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      run(1'b0, 1'b1);
      if (if_id_valid) begin
        chk("wait_first_pc", if_id_pc, 32'h0);
        found = 1'b1;
      end
    end
    chk("wait_first_seen", 32'(found), 1);

    // Decode stall: FIFO fills and fetch stops, then resumes in order.
    for (int i = 0; i < 4; i++) run(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) run(1'b1, 1'b1);
    chk("stall_full_no_req", 32'(imem_req_valid), 0);
    last_del = deliveries;
    for (int i = 0; i < 10; i++) run(1'b0, 1'b1);
    chk("stall_resume", 32'(deliveries > last_del), 1);

    // Redirect while the 0x10 fetch is in flight.
    lat = 3;
    do_reset(2);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      run(1'b0, 1'b1);
      found = last_hs && (last_hs_addr == 32'h10);
    end
    chk("redir_hs_0x10", 32'(found), 1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102);
    run(1'b0, 1'b1);
    chk("redir_next_if_valid", 32'(if_id_valid), 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_req_valid) begin
        chk("redir_new_addr", imem_addr, 32'h100);
        found = 1'b1;
      end else run(1'b0, 1'b1);
    end
    chk("redir_req_seen", 32'(found), 1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      run(1'b0, 1'b1);
      if (if_id_valid) begin
        chk("redir_first_pc", if_id_pc, 32'h100);
        found = 1'b1;
      end
    end
    chk("redir_first_seen", 32'(found), 1);

    // Redirect + stall + response in the same cycle.
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      run(1'b0, 1'b1);
      found = last_hs;
    end
    chk("rs_hs_seen", 32'(found), 1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    run(1'b0, 1'b1);
    chk("rs_if_valid", 32'(if_id_valid), 0);
    chk("rs_req_valid", 32'(imem_req_valid), 1);
    chk("rs_req_addr", imem_addr, 32'h200);

    // Reset with the in-flight response landing during reset.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      run(1'b0, 1'b1);
      found = last_hs;
    end
    do_reset(2);
    run(1'b0, 1'b0);
    chk("rst1_req_valid", 32'(imem_req_valid), 1);
    chk("rst1_req_addr", imem_addr, 32'h0);
    for (int i = 0; i < 8; i++) run(1'b0, 1'b1);

    // Reset with the stale response landing just after release.
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      run(1'b0, 1'b1);
      found = last_hs;
    end
    do_reset(2);
    run(1'b0, 1'b0);
    chk("rst2_req_addr", imem_addr, 32'h0);
    last_del = deliveries;
    for (int i = 0; i < 12; i++) run(1'b0, 1'b1);
    chk("rst2_resume", 32'(deliveries > last_del), 1);

    // Random traffic checked by the stream model.
    rand_lat = 1'b1;
    last_del = deliveries;
    idle = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF4;
      else rpc = $urandom;
      step(1'b1, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7,
           $urandom_range(0, 49) == 0, rpc);
      if (deliveries == last_del) idle++;
      else idle = 0;
      last_del = deliveries;
      if (idle > 300) begin
        chk("rand_progress", 32'(idle), 0);
        break;
      end
    end
    chk("rand_some_delivered", 32'(deliveries > 300), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
